// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the two requester ports (A = CPU load/store path, B = loader/DMA)
// and the MemArray data-port side of the arbiter into one interface.
//   a_req/a_we/a_addr/a_din    requester A request, direction, byte address, write data
//   a_gnt/a_rvalid/a_dout      grant (combinational), read-return valid, read data
//   b_*                        same set for requester B
//   m_addr/m_din/m_we          to MemArray ADDR1/DIN/WE
//   m_dout                     from MemArray DOUT1 (valid one cycle after address)
// Modport slave is the arbiter's view; master is the requesters/memory view.
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int DBITS = 16,
    parameter int ABITS = 12
);
    logic             a_req;
    logic             a_we;
    logic [DBITS-1:0] a_addr;
    logic [DBITS-1:0] a_din;
    logic             a_gnt;
    logic             a_rvalid;
    logic [DBITS-1:0] a_dout;

    logic             b_req;
    logic             b_we;
    logic [DBITS-1:0] b_addr;
    logic [DBITS-1:0] b_din;
    logic             b_gnt;
    logic             b_rvalid;
    logic [DBITS-1:0] b_dout;

    logic [ABITS-1:0] m_addr;
    logic [DBITS-1:0] m_din;
    logic             m_we;
    logic [DBITS-1:0] m_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_din,
        output a_gnt, a_rvalid, a_dout,
        input  b_req, b_we, b_addr, b_din,
        output b_gnt, b_rvalid, b_dout,
        output m_addr, m_din, m_we,
        input  m_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_din,
        input  a_gnt, a_rvalid, a_dout,
        output b_req, b_we, b_addr, b_din,
        input  b_gnt, b_rvalid, b_dout,
        input  m_addr, m_din, m_we,
        output m_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single MemArray data port between requester A (CPU, normally
// priority) and requester B (program loader / debug DMA). A wins ties unless
// B has been denied STARVE_MAX consecutive cycles, in which case B gets one
// forced slot. A denied a_gnt acts as the CPU pipeline stall.
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    dmem_port_arbiter_if.slave: both requester ports + MemArray port
// Writes outside the MemArray byte range are granted but not written; reads
// return whatever MemArray presents for the truncated word address.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int DBITS      = 16,
    parameter int ABITS      = 12,
    parameter int STARVE_MAX = 4,
    parameter int CBITS      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_port_arbiter_if.slave    bus
);

    typedef enum logic {
        PRI_A,
        PRI_B
    } pri_t;

    localparam logic [CBITS-1:0] STARVE_LIM = CBITS'(STARVE_MAX);

    pri_t             state_q;
    pri_t             state_d;
    logic [CBITS-1:0] starve_q;
    logic [CBITS-1:0] starve_d;
    logic [CBITS-1:0] starve_inc;
    logic [1:0]       rd_owner_q;
    logic [ABITS-1:0] addr_hold_q;
    logic [DBITS-1:0] din_hold_q;

    logic             a_gnt;
    logic             b_gnt;
    logic             any_gnt;
    logic             sel_we;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_din;
    logic             sel_in_range;
    logic             unused_addr_bit0;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (state_q == PRI_A) begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req & ~bus.a_req;
            end else begin
                b_gnt = bus.b_req;
                a_gnt = bus.a_req & ~bus.b_req;
            end
        end
    end

    // Select the granted port's request fields for the memory side.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        if (a_gnt) begin
            sel_we   = bus.a_we;
            sel_addr = bus.a_addr;
            sel_din  = bus.a_din;
        end else if (b_gnt) begin
            sel_we   = bus.b_we;
            sel_addr = bus.b_addr;
            sel_din  = bus.b_din;
        end
    end

    assign any_gnt          = a_gnt | b_gnt;
    assign sel_in_range     = (sel_addr[DBITS-1:ABITS+1] == '0);
    assign unused_addr_bit0 = sel_addr[0];

    // Without a grant the memory address/data lines keep their last value.
    assign bus.m_addr = any_gnt ? sel_addr[ABITS:1] : addr_hold_q;
    assign bus.m_din  = any_gnt ? sel_din : din_hold_q;
    assign bus.m_we   = any_gnt & sel_we & sel_in_range;

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = rd_owner_q[1] & ~reset;
    assign bus.b_rvalid = rd_owner_q[0] & ~reset;
    assign bus.a_dout   = bus.a_rvalid ? bus.m_dout : '0;
    assign bus.b_dout   = bus.b_rvalid ? bus.m_dout : '0;

    // Starvation counter and priority state. The forced slot lasts exactly
    // one cycle in which B is either served or has withdrawn its request.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        starve_inc = starve_q + 1'b1;
        if (bus.b_req && !b_gnt) begin
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_inc;
                if (state_q == PRI_A && starve_inc == STARVE_LIM) begin
                    state_d = PRI_B;
                end
            end
        end else begin
            starve_d = '0;
        end
        if (state_q == PRI_B && (b_gnt || !bus.b_req)) begin
            state_d  = PRI_A;
            starve_d = '0;
        end
    end

    // State registers, read ownership for the next-cycle return, and the
    // held memory address/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PRI_A;
            starve_q    <= '0;
            rd_owner_q  <= 2'b00;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_owner_q <= {a_gnt & ~bus.a_we, b_gnt & ~bus.b_we};
            if (any_gnt) begin
                addr_hold_q <= sel_addr[ABITS:1];
                din_hold_q  <= sel_din;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Drives both requester ports of dmem_port_arbiter, emulates MemArray
// (synchronous read, write-before-read), and compares every cycle against a
// reference model built from the arbitration rules: B wins when it requests
// and either A is idle or B has already been refused STARVE_MAX cycles in a
// row; a shadow memory supplies expected read data.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int DBITS      = 16;
    localparam int ABITS      = 12;
    localparam int STARVE_MAX = 4;
    localparam int CBITS      = 3;
    localparam int WORDS      = 1 << ABITS;

    logic clk;
    logic reset;

    dmem_port_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

    dmem_port_arbiter #(
        .DBITS(DBITS), .ABITS(ABITS), .STARVE_MAX(STARVE_MAX), .CBITS(CBITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MemArray emulation: write on posedge, read data registered, new data
    // visible to a read of the same word.
    logic [DBITS-1:0] memArr [WORDS];
    always @(posedge clk) begin
        if (bus.m_we) begin
            memArr[bus.m_addr] <= bus.m_din;
            bus.m_dout         <= bus.m_din;
        end else begin
            bus.m_dout <= memArr[bus.m_addr];
        end
    end

    // Reference model state.
    logic [DBITS-1:0] shadow [WORDS];
    int               streak;
    logic             expRvA, expRvB;
    logic [DBITS-1:0] expDataA, expDataB;
    logic [ABITS-1:0] lastAddr;
    logic [DBITS-1:0] lastDin;
    logic             sawBGnt;

    int compared;
    int mismatched;

    task automatic checkOutput(input string tag, input logic [DBITS-1:0] observed,
                               input logic [DBITS-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model,
    // advance the model, then move to just after the next posedge.
    task automatic applyStimulus(
        input logic rstV,
        input logic aReq, input logic aWe, input logic [DBITS-1:0] aAddr, input logic [DBITS-1:0] aDin,
        input logic bReq, input logic bWe, input logic [DBITS-1:0] bAddr, input logic [DBITS-1:0] bDin);
        logic             expGA, expGB, expWe, inRange;
        logic [ABITS-1:0] expAddr;
        logic [DBITS-1:0] expDin;
        logic             nextRvA, nextRvB;

        reset      = rstV;
        bus.a_req  = aReq;  bus.a_we = aWe;  bus.a_addr = aAddr;  bus.a_din = aDin;
        bus.b_req  = bReq;  bus.b_we = bWe;  bus.b_addr = bAddr;  bus.b_din = bDin;
        #2;

        if (rstV) begin
            expGA = 1'b0;
            expGB = 1'b0;
        end else begin
            expGB = bReq && (!aReq || streak >= STARVE_MAX);
            expGA = aReq && !expGB;
        end
        expAddr = lastAddr;
        expDin  = lastDin;
        expWe   = 1'b0;
        if (expGA) begin
            expAddr = aAddr[ABITS:1];
            expDin  = aDin;
            expWe   = aWe && (aAddr[DBITS-1:ABITS+1] == '0);
        end else if (expGB) begin
            expAddr = bAddr[ABITS:1];
            expDin  = bDin;
            expWe   = bWe && (bAddr[DBITS-1:ABITS+1] == '0);
        end

        sawBGnt = bus.b_gnt;
        checkOutput("a_gnt", 16'(bus.a_gnt), 16'(expGA));
        checkOutput("b_gnt", 16'(bus.b_gnt), 16'(expGB));
        checkOutput("m_we", 16'(bus.m_we), 16'(expWe));
        checkOutput("a_rvalid", 16'(bus.a_rvalid), 16'(expRvA && !rstV));
        checkOutput("b_rvalid", 16'(bus.b_rvalid), 16'(expRvB && !rstV));
        checkOutput("a_dout", bus.a_dout, (expRvA && !rstV) ? expDataA : 16'h0000);
        checkOutput("b_dout", bus.b_dout, (expRvB && !rstV) ? expDataB : 16'h0000);
        if (!rstV) begin
            checkOutput("m_addr", 16'(bus.m_addr), 16'(expAddr));
            checkOutput("m_din", bus.m_din, expDin);
        end

        if (rstV) begin
            streak   = 0;
            expRvA   = 1'b0;
            expRvB   = 1'b0;
            lastAddr = '0;
            lastDin  = '0;
        end else begin
            nextRvA = 1'b0;
            nextRvB = 1'b0;
            if (expGA || expGB) begin
                lastAddr = expAddr;
                lastDin  = expDin;
                inRange  = expGA ? (aAddr[DBITS-1:ABITS+1] == '0) : (bAddr[DBITS-1:ABITS+1] == '0);
                if (expGA ? aWe : bWe) begin
                    if (inRange) shadow[expAddr] = expDin;
                end else if (expGA) begin
                    nextRvA  = 1'b1;
                    expDataA = shadow[expAddr];
                end else begin
                    nextRvB  = 1'b1;
                    expDataB = shadow[expAddr];
                end
            end
            expRvA = nextRvA;
            expRvB = nextRvB;
            if (bReq && !expGB) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
            else streak = 0;
        end

        @(posedge clk);
        #1;
    endtask

    function automatic logic [DBITS-1:0] randAddr();
        logic [DBITS-1:0] a;
        a = 16'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) a[DBITS-1:ABITS+1] = 3'($urandom_range(1, 7));
        return a;
    endfunction

    initial begin
        int bGrants;
        compared   = 0;
        mismatched = 0;
        streak     = 0;
        expRvA     = 1'b0;
        expRvB     = 1'b0;
        expDataA   = '0;
        expDataB   = '0;
        lastAddr   = '0;
        lastDin    = '0;
        for (int i = 0; i < WORDS; i++) begin
            memArr[i] = 16'($urandom);
            shadow[i] = memArr[i];
        end

        // Reset
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // A-only read of 0x0204 (word 0x102), then its return
        applyStimulus(0, 1, 0, 16'h0204, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t1_a_dout", bus.a_dout, shadow[12'h102]);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Both held: B forced through on cycles 5 and 10
        bGrants = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 1, 0, 16'h0004, 16'h0, 1, 0, 16'h0006, 16'h0);
            if (sawBGnt) bGrants++;
        end
        checkOutput("t2_b_grants", 16'(bGrants), 16'd2);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // B write then A read of the same address
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
        applyStimulus(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t3_a_dout", bus.a_dout, 16'hBEEF);
        checkOutput("t3_b_rvalid", 16'(bus.b_rvalid), 16'd0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Out-of-range write dropped, top in-range word written
        applyStimulus(0, 1, 1, 16'hFFF8, 16'h1234, 0, 0, 16'h0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h1FFE, 16'h5A5A);
        applyStimulus(0, 1, 0, 16'hFFF8, 16'h0, 0, 0, 16'h0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h1FFE, 16'h0);
        checkOutput("t4_b_dout", bus.b_dout, 16'h5A5A);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Starving B withdraws for one cycle: counter restarts
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0002, 16'h0, 1, 0, 16'h0008, 16'h0);
        applyStimulus(0, 1, 0, 16'h0002, 16'h0, 0, 0, 16'h0008, 16'h0);
        bGrants = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 16'h0002, 16'h0, 1, 0, 16'h0008, 16'h0);
            if (sawBGnt) bGrants++;
        end
        checkOutput("t5_b_grants", 16'(bGrants), 16'd1);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Reset while in forced-B state with an A read pending
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'h000A, 16'h0, 1, 0, 16'h000C, 16'h0);
        applyStimulus(1, 1, 0, 16'h000A, 16'h0, 1, 0, 16'h000C, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 16'h000A, 16'h0, 1, 0, 16'h000C, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0), 1'($urandom), randAddr(), 16'($urandom),
                          ($urandom_range(0, 3) != 0), 1'($urandom), randAddr(), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
